// File: rtl/fp_32_pkg.sv
// Shared binary32 constants, operand classes and the classifier used by the
// floating-point datapath blocks (adder, fp-to-int converter).
package fp_32_pkg;

  localparam int          EXP_BIAS    = 127;
  localparam logic [7:0]  EXP_SPECIAL = 8'hFF;
  localparam logic [31:0] INT32_MAX   = 32'h7FFFFFFF;
  localparam logic [31:0] INT32_MIN   = 32'h80000000;

  // Biased exponents where the integer LSB lines up with the significand LSB,
  // where |x| reaches 0.5, and where |x| reaches 2^31.
  localparam logic [7:0]  EXP_INT_LSB = 8'(EXP_BIAS + 23);
  localparam logic [7:0]  EXP_HALF    = 8'(EXP_BIAS - 1);
  localparam logic [7:0]  EXP_INT_OVF = 8'(EXP_BIAS + 31);

  // -2^31 is the only operand at or above EXP_INT_OVF that still fits.
  localparam logic [31:0] FP_NEG_2_31 = 32'hCF000000;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_DENORM,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_t;

  function automatic fp_class_t fp_classify(input logic [31:0] w);
    fp_class_t cls;
    if (w[30:23] == 8'h00) begin
      cls = (w[22:0] == 23'd0) ? FP_ZERO : FP_DENORM;
    end else if (w[30:23] == EXP_SPECIAL) begin
      cls = (w[22:0] == 23'd0) ? FP_INF : FP_NAN;
    end else begin
      cls = FP_NORMAL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp_32_align_shift.sv
// Aligns a normal 24-bit significand to the integer grid: integer part,
// guard bit, sticky bit and an overflow indication for |x| >= 2^31.
module fp_32_align_shift
  import fp_32_pkg::*;
(
  input  logic [23:0] sig,
  input  logic [7:0]  exp,
  output logic [31:0] int_part,
  output logic        guard,
  output logic        sticky,
  output logic        overflow
);

  logic [4:0]  rshamt;
  logic [2:0]  lshamt;
  logic [47:0] rwide;

  always_comb begin
    int_part = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    overflow = 1'b0;
    rshamt   = 5'(EXP_INT_LSB - exp);
    lshamt   = 3'(exp - EXP_INT_LSB);
    rwide    = '0;

    if (exp >= EXP_INT_OVF) begin
      overflow = 1'b1;
    end else if (exp >= EXP_INT_LSB) begin
      int_part = {8'd0, sig} << lshamt;
    end else if (exp >= EXP_HALF) begin
      // Shift 1..24 places; the upper half is the integer, the lower half
      // holds the guard bit followed by everything that feeds sticky.
      rwide    = {sig, 24'd0} >> rshamt;
      int_part = {8'd0, rwide[47:24]};
      guard    = rwide[23];
      sticky   = |rwide[22:0];
    end else begin
      sticky = 1'b1;
    end
  end

endmodule

// File: rtl/fp_32_to_int.sv
// Three-stage binary32 -> int32 converter: classify, align, then round to
// nearest-even, negate and saturate into registered outputs.
module fp_32_to_int
  import fp_32_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_out,
  output logic        invalid,
  output logic        inexact
);

  // Handshake: a word moves on any rising edge where valid and ready are both
  // high. The whole pipe advances on en; it only freezes when a result is
  // waiting and the consumer refuses it, so in_ready follows out_ready
  // combinationally and outputs stay stable while out_valid & !out_ready.
  logic en;
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Stage 1: operand fields and class
  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q,  s1_sign_d;
  fp_class_t   s1_cls_q,   s1_cls_d;
  logic [7:0]  s1_exp_q,   s1_exp_d;
  logic [23:0] s1_sig_q,   s1_sig_d;
  logic        s1_min_q,   s1_min_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_cls_d   = s1_cls_q;
    s1_exp_d   = s1_exp_q;
    s1_sig_d   = s1_sig_q;
    s1_min_d   = s1_min_q;
    if (en) begin
      s1_valid_d = in_valid;
      s1_sign_d  = fp_data[31];
      s1_cls_d   = fp_classify(fp_data);
      s1_exp_d   = fp_data[30:23];
      s1_sig_d   = {fp_data[30:23] != 8'h00, fp_data[22:0]};
      s1_min_d   = (fp_data == FP_NEG_2_31);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_cls_q   <= FP_ZERO;
      s1_exp_q   <= '0;
      s1_sig_q   <= '0;
      s1_min_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_cls_q   <= s1_cls_d;
      s1_exp_q   <= s1_exp_d;
      s1_sig_q   <= s1_sig_d;
      s1_min_q   <= s1_min_d;
    end
  end

  // Stage 2: alignment
  logic [31:0] al_int;
  logic        al_guard, al_sticky, al_ovf;

  fp_32_align_shift u_align (
    .sig      (s1_sig_q),
    .exp      (s1_exp_q),
    .int_part (al_int),
    .guard    (al_guard),
    .sticky   (al_sticky),
    .overflow (al_ovf)
  );

  logic        s2_valid_q,  s2_valid_d;
  logic        s2_sign_q,   s2_sign_d;
  fp_class_t   s2_cls_q,    s2_cls_d;
  logic [31:0] s2_mag_q,    s2_mag_d;
  logic        s2_guard_q,  s2_guard_d;
  logic        s2_sticky_q, s2_sticky_d;
  logic        s2_ovf_q,    s2_ovf_d;
  logic        s2_min_q,    s2_min_d;

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_cls_d    = s2_cls_q;
    s2_mag_d    = s2_mag_q;
    s2_guard_d  = s2_guard_q;
    s2_sticky_d = s2_sticky_q;
    s2_ovf_d    = s2_ovf_q;
    s2_min_d    = s2_min_q;
    if (en) begin
      s2_valid_d  = s1_valid_q;
      s2_sign_d   = s1_sign_q;
      s2_cls_d    = s1_cls_q;
      s2_mag_d    = al_int;
      s2_guard_d  = al_guard;
      s2_sticky_d = al_sticky;
      s2_ovf_d    = al_ovf;
      s2_min_d    = s1_min_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_cls_q    <= FP_ZERO;
      s2_mag_q    <= '0;
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      s2_ovf_q    <= 1'b0;
      s2_min_q    <= 1'b0;
    end else begin
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_cls_q    <= s2_cls_d;
      s2_mag_q    <= s2_mag_d;
      s2_guard_q  <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d;
      s2_ovf_q    <= s2_ovf_d;
      s2_min_q    <= s2_min_d;
    end
  end

  // Stage 3: round, negate, saturate
  logic        rnd_inc;
  logic [31:0] mag_rnd;
  logic [31:0] signed_res;
  logic [31:0] sat_val;

  logic        out_valid_q, out_valid_d;
  logic [31:0] int_out_q,   int_out_d;
  logic        invalid_q,   invalid_d;
  logic        inexact_q,   inexact_d;

  always_comb begin
    rnd_inc    = s2_guard_q & (s2_sticky_q | s2_mag_q[0]);
    mag_rnd    = s2_mag_q + {31'd0, rnd_inc};
    // A magnitude that rounds to zero negates to zero, so no -0 escapes.
    signed_res = s2_sign_q ? (~mag_rnd + 32'd1) : mag_rnd;
    sat_val    = s2_sign_q ? INT32_MIN : INT32_MAX;

    out_valid_d = out_valid_q;
    int_out_d   = int_out_q;
    invalid_d   = invalid_q;
    inexact_d   = inexact_q;
    if (en) begin
      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        case (s2_cls_q)
          FP_ZERO: begin
            int_out_d = '0;
            invalid_d = 1'b0;
            inexact_d = 1'b0;
          end
          FP_DENORM: begin
            int_out_d = '0;
            invalid_d = 1'b0;
            inexact_d = 1'b1;
          end
          FP_NAN: begin
            int_out_d = INT32_MAX;
            invalid_d = 1'b1;
            inexact_d = 1'b0;
          end
          FP_INF: begin
            int_out_d = sat_val;
            invalid_d = 1'b1;
            inexact_d = 1'b0;
          end
          default: begin
            if (s2_ovf_q && s2_min_q) begin
              int_out_d = INT32_MIN;
              invalid_d = 1'b0;
              inexact_d = 1'b0;
            end else if (s2_ovf_q) begin
              int_out_d = sat_val;
              invalid_d = 1'b1;
              inexact_d = 1'b0;
            end else begin
              int_out_d = signed_res;
              invalid_d = 1'b0;
              inexact_d = s2_guard_q | s2_sticky_q;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      int_out_q   <= '0;
      invalid_q   <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      int_out_q   <= int_out_d;
      invalid_q   <= invalid_d;
      inexact_q   <= inexact_d;
    end
  end

  assign out_valid = out_valid_q;
  assign int_out   = int_out_q;
  assign invalid   = invalid_q;
  assign inexact   = inexact_q;

endmodule
